// File: rtl/mem_access.sv
// mem_access: MEM stage that serialises loads/stores into little-endian byte transactions and stalls until done.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] memaddr_i,
  input  logic              memwr_i,
  input  logic [1:0]        memcnf_i,
  input  logic              memsigned_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wbyte_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [7:0]        mem_rbyte_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              mem_stall_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_LAST, DONE} state_t;
  state_t state, state_n;
  logic [2:0] issue_cnt, recv_cnt, n;
  logic [DATA_W-1:0] buffer, load_data;
  logic rx, pass, ld_done;
  assign n  = memcnf_i == 2'd3 ? 3'd4 : {1'b0, memcnf_i};
  assign rx = mem_rvalid_i && (state == ACCESS || state == WAIT_LAST);
  always_ff @(posedge clk) begin
    if (rst || state == DONE) begin
      state     <= rst ? IDLE : state_n;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      buffer    <= '0;
    end else begin
      state <= state_n;
      if (state == ACCESS && mem_gnt_i) issue_cnt <= issue_cnt + 3'd1;
      if (rx) begin
        buffer[8*recv_cnt[1:0] +: 8] <= mem_rbyte_i;
        recv_cnt <= recv_cnt + 3'd1;
      end
    end
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && memcnf_i != 2'd0) state_n = ACCESS;
    if (state == ACCESS && mem_gnt_i && issue_cnt == n - 3'd1) state_n = memwr_i ? DONE : WAIT_LAST;
    if (state == WAIT_LAST && recv_cnt + {2'b0, rx} == n) state_n = DONE;
    if (state == DONE) state_n = IDLE;
  end
  // Extension uses the size still held on the inputs by the stall.
  assign load_data = memcnf_i == 2'd1 ? {{(DATA_W-8){memsigned_i & buffer[7]}}, buffer[7:0]} :
                     memcnf_i == 2'd2 ? {{(DATA_W-16){memsigned_i & buffer[15]}}, buffer[15:0]} : buffer;
  assign pass    = state == IDLE && memcnf_i == 2'd0;
  assign ld_done = state == DONE && !memwr_i;
  always_comb begin
    mem_req_o   = !rst && state == ACCESS;
    mem_addr_o  = mem_req_o ? memaddr_i + ADDR_W'(issue_cnt) : '0;
    mem_we_o    = mem_req_o && memwr_i;
    mem_wbyte_o = mem_req_o ? wdata_i[8*issue_cnt[1:0] +: 8] : 8'd0;
    mem_stall_o = !rst && (state == ACCESS || state == WAIT_LAST || (state == IDLE && memcnf_i != 2'd0));
    wd_o        = rst ? 5'd0 : wd_i;
    wreg_o      = !rst && (pass || ld_done) && wreg_i;
    wdata_o     = rst ? '0 : pass ? wdata_i : ld_done ? load_data : '0;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven and randomized checks of mem_access against a byte-memory reference model.
module tb_mem_access;
  logic clk = 0, rst = 1;
  logic [4:0] wd_i = 0;
  logic wreg_i = 0, memwr_i = 0, memsigned_i = 0;
  logic [31:0] wdata_i = 0, memaddr_i = 0;
  logic [1:0] memcnf_i = 0;
  logic mem_req_o, mem_we_o, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] mem_addr_o;
  logic [7:0] mem_wbyte_o, mem_rbyte_i = 0;
  logic [4:0] wd_o;
  logic wreg_o, mem_stall_o;
  logic [31:0] wdata_o;

  mem_access dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .memaddr_i(memaddr_i), .memwr_i(memwr_i), .memcnf_i(memcnf_i), .memsigned_i(memsigned_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wbyte_o(mem_wbyte_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rbyte_i(mem_rbyte_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .mem_stall_o(mem_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cnf; logic wr; logic sgn; logic [31:0] addr; logic [31:0] wdata;
    logic [4:0] wd; logic wreg; int delay; logic [31:0] exp_wdata; logic exp_wreg; int exp_stalls;
  } vec_t;

  int passed = 0, total = 0;
  logic [7:0] mem [logic [31:0]];
  logic [40:0] txq [$];
  int gnt_delay = 0, low_cnt = 0;
  bit rand_gnt = 0, pend = 0, hold_valid = 0;
  logic [7:0] pend_b;
  logic [40:0] held;
  logic [31:0] got_wdata;
  logic got_wreg;
  logic [4:0] got_wd;
  int stalls;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [7:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h3C);
  endfunction

  // Reference load: gather N bytes little-endian, then sign-extend by subtracting 2^(8N).
  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] cnf, logic sgn);
    int nb = cnf == 2'd3 ? 4 : int'(cnf);
    logic [63:0] v = 0;
    for (int k = 0; k < nb; k++) v += 64'(rd(a + 32'(k))) << (8 * k);
    if (sgn && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  // One clock: act as the byte controller, then advance past the edge.
  task automatic tick();
    #1;
    if (mem_req_o) begin
      if (hold_valid) chk("req_hold", {mem_we_o, mem_addr_o, mem_wbyte_o}, held[40:0]);
      mem_gnt_i = rand_gnt ? ($urandom_range(0, 2) != 0) : (low_cnt >= gnt_delay);
      if (mem_gnt_i) begin
        low_cnt = 0; hold_valid = 0;
        txq.push_back({mem_we_o, mem_addr_o, mem_wbyte_o});
        if (mem_we_o) mem[mem_addr_o] = mem_wbyte_o;
        else begin pend = 1; pend_b = rd(mem_addr_o); end
      end else begin
        low_cnt++; hold_valid = 1; held = {mem_we_o, mem_addr_o, mem_wbyte_o};
      end
    end else begin
      low_cnt = 0; hold_valid = 0;
    end
    @(posedge clk); #1;
    mem_gnt_i = 0; mem_rvalid_i = pend; mem_rbyte_i = pend ? pend_b : 8'h00; pend = 0;
  endtask

  task automatic run_access(vec_t v);
    bit done = 0;
    memcnf_i = v.cnf; memwr_i = v.wr; memsigned_i = v.sgn; memaddr_i = v.addr;
    wdata_i = v.wdata; wd_i = v.wd; wreg_i = v.wreg; gnt_delay = v.delay;
    txq.delete(); stalls = 0;
    #1;
    if (v.cnf != 0) chk("start_stall", 32'(mem_stall_o), 32'd1);
    for (int c = 0; c < 300 && !done; c++) begin
      if (!mem_stall_o && (c > 0 || v.cnf == 0)) begin
        done = 1; got_wdata = wdata_o; got_wreg = wreg_o; got_wd = wd_o;
        memcnf_i = 0;
      end else if (c > 0) stalls++;
      tick();
    end
    if (!done) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic check_txns(vec_t v, string tag);
    int nb = v.cnf == 2'd3 ? 4 : int'(v.cnf);
    chk({tag, "_ntxn"}, 32'(txq.size()), 32'(nb));
    for (int k = 0; k < nb && k < txq.size(); k++) begin
      chk({tag, "_addr"}, txq[k][39:8], v.addr + 32'(k));
      chk({tag, "_we"}, 32'(txq[k][40]), 32'(v.wr));
      if (v.wr) chk({tag, "_wbyte"}, 32'(txq[k][7:0]), (v.wdata >> (8 * k)) & 32'hFF);
    end
  endtask

  vec_t vecs [10];

  initial begin
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem[32'h20] = 8'h80; mem[32'h40] = 8'h00; mem[32'h41] = 8'h80;
    //          cnf   wr    sgn   addr           wdata          wd     wreg  dly exp_wdata      wreg  stalls
    vecs[0] = '{2'd0, 1'b0, 1'b0, 32'h0,         32'h0000_1234, 5'd5,  1'b1, 0, 32'h0000_1234, 1'b1, 0};
    vecs[1] = '{2'd3, 1'b0, 1'b0, 32'h100,       32'h0,         5'd7,  1'b1, 0, 32'h1234_5678, 1'b1, 5};
    vecs[2] = '{2'd1, 1'b0, 1'b1, 32'h20,        32'h0,         5'd8,  1'b1, 0, 32'hFFFF_FF80, 1'b1, 2};
    vecs[3] = '{2'd1, 1'b0, 1'b0, 32'h20,        32'h0,         5'd9,  1'b1, 0, 32'h0000_0080, 1'b1, 2};
    vecs[4] = '{2'd2, 1'b0, 1'b1, 32'h40,        32'h0,         5'd10, 1'b1, 0, 32'hFFFF_8000, 1'b1, 3};
    vecs[5] = '{2'd2, 1'b0, 1'b0, 32'h40,        32'h0,         5'd11, 1'b1, 1, 32'h0000_8000, 1'b1, 5};
    vecs[6] = '{2'd2, 1'b1, 1'b0, 32'h202,       32'h0000_ABCD, 5'd12, 1'b1, 3, 32'h0,         1'b0, 8};
    vecs[7] = '{2'd3, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 5'd13, 1'b1, 0, 32'h0,         1'b0, 4};
    vecs[8] = '{2'd3, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0,         5'd14, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 5};
    vecs[9] = '{2'd2, 1'b0, 1'b0, 32'h202,       32'h0,         5'd15, 1'b1, 2, 32'h0000_ABCD, 1'b1, 7};

    wdata_i = 32'h55; wd_i = 5'd3; wreg_i = 1;
    tick(); tick();
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_stall", 32'(mem_stall_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wd_wreg", {26'd0, wd_o, wreg_o}, 0);
    rst = 0;

    foreach (vecs[i]) begin
      run_access(vecs[i]);
      chk($sformatf("v%0d_wdata", i), got_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_wreg", i), 32'(got_wreg), 32'(vecs[i].exp_wreg));
      chk($sformatf("v%0d_wd", i), 32'(got_wd), 32'(vecs[i].wd));
      chk($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
      check_txns(vecs[i], $sformatf("v%0d", i));
    end

    // Reset after the second grant of a word load aborts the access.
    memcnf_i = 2'd3; memwr_i = 0; memaddr_i = 32'h100; wd_i = 5'd6; wreg_i = 1; gnt_delay = 0;
    txq.delete();
    tick(); tick(); tick();
    chk("abort_grants", 32'(txq.size()), 32'd2);
    rst = 1;
    tick();
    chk("abort_req", 32'(mem_req_o), 0);
    chk("abort_stall", 32'(mem_stall_o), 0);
    chk("abort_addr", mem_addr_o, 0);
    chk("abort_wdata", wdata_o, 0);
    chk("abort_wd_wreg", {26'd0, wd_o, wreg_o}, 0);
    memcnf_i = 0;
    tick();
    rst = 0;
    begin
      vec_t v = '{2'd1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd4, 1'b1, 0, 32'h80, 1'b1, 2};
      run_access(v);
      chk("post_rst_wdata", got_wdata, 32'h80);
      chk("post_rst_stalls", 32'(stalls), 32'd2);
      check_txns(v, "post_rst");
    end

    rand_gnt = 1;
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      logic [31:0] exp;
      v.cnf = 2'($urandom_range(0, 3)); v.wr = 1'($urandom); v.sgn = 1'($urandom);
      v.addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 63));
      v.wdata = $urandom; v.wd = 5'($urandom); v.wreg = 1'($urandom); v.delay = 0;
      exp = v.cnf == 0 ? v.wdata : v.wr ? 32'h0 : model_load(v.addr, v.cnf, v.sgn);
      run_access(v);
      chk("rnd_wdata", got_wdata, exp);
      chk("rnd_wreg", 32'(got_wreg), 32'(v.cnf == 0 || !v.wr ? v.wreg : 1'b0));
      check_txns(v, "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the RISC-V pipeline; sits between the EX/MEM latch and the byte-wide memory controller.
- Consumes the memory request produced by EX:
  - address
  - load/store flag
  - size code (0 none, 1 B, 2 H, 3 W)
  - signed flag
  - store data / ALU result
- Serialises each access into little-endian byte transactions, assembles and sign/zero-extends load data, and forwards the writeback triple to MEM/WB.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, register/data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wd_i  in  5  destination register from EX/MEM.
- wreg_i  in  1  destination write enable from EX/MEM.
- wdata_i  in  32  ALU result (non-mem op) or store data (store).
- memaddr_i  in  32  byte address of access.
- memwr_i  in  1  0 load, 1 store.
- memcnf_i  in  2  0 no access, 1 byte, 2 half, 3 word.
- memsigned_i  in  1  1 sign-extend load, 0 zero-extend.
- mem_req_o  out  1  byte transaction request.
- mem_addr_o  out  32  byte address of current transaction.
- mem_we_o  out  1  1 write byte, 0 read byte.
- mem_wbyte_o  out  8  byte to write.
- mem_gnt_i  in  1  controller accepted the current byte this cycle.
- mem_rvalid_i  in  1  read byte valid (exactly one cycle after its grant).
- mem_rbyte_i  in  8  read byte.
- wd_o  out  5  destination register to MEM/WB.
- wreg_o  out  1  write enable to MEM/WB.
- wdata_o  out  32  writeback data to MEM/WB.
- mem_stall_o  out  1  hold IF..EX/MEM latches.

Behaviour:
- Reset:
  - State IDLE; issue and receive counters cleared; assembly buffer 0.
  - All outputs 0: mem_req_o, mem_addr_o, mem_we_o, mem_wbyte_o, wd_o, wreg_o, wdata_o, mem_stall_o.
  - Reset mid-access aborts immediately: mem_req_o drops the next cycle, no further bytes are issued, and partial load data is discarded.
- Byte count N: 1 for memcnf=1, 2 for memcnf=2, 4 for memcnf=3.
  - Byte k (k=0..N-1) goes to memaddr_i+k and carries data bits [8k+7:8k] (little-endian).
  - No alignment check; the address increments with plain 32-bit wrap (0xFFFFFFFF+1 = 0).
- IDLE:
  - memcnf_i=0: combinational pass-through (wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i), mem_stall_o=0, zero latency.
  - memcnf_i!=0: mem_stall_o=1 combinationally in the same cycle; wreg_o=0; transition to ACCESS.
- ACCESS:
  - mem_req_o=1, mem_addr_o=memaddr_i+issue_cnt, mem_we_o=memwr_i, mem_wbyte_o=wdata_i byte[issue_cnt].
  - A cycle with mem_gnt_i=1 counts that byte as issued and increments issue_cnt; addr/byte advance the next cycle.
  - If mem_gnt_i=0, all request outputs are held unchanged.
  - Store: when the grant of byte N-1 arrives, go to DONE.
  - Load: when the grant of byte N-1 arrives, go to WAIT_LAST.
- Load receive:
  - Any cycle with mem_rvalid_i=1 (in ACCESS or WAIT_LAST) writes mem_rbyte_i into buffer byte[recv_cnt] and increments recv_cnt.
  - Reads are pipelined: byte k+1 may be granted in the same cycle byte k's data returns.
- WAIT_LAST: mem_req_o=0; when recv_cnt reaches N (after last rvalid), go to DONE.
- DONE (exactly one cycle):
  - mem_stall_o=0, mem_req_o=0, wd_o=wd_i.
  - Load: wreg_o=wreg_i; wdata_o is the buffer extended per size:
    - B: bit 7 replicated if memsigned_i else zeros.
    - H: bit 15 replicated if memsigned_i else zeros.
    - W: unchanged.
  - Store: wreg_o=0, wdata_o=0.
  - The pipeline advances at this edge; next state is IDLE, counters and buffer cleared.
- Inputs are held stable by the stall for the whole access; the block does not latch them.
- mem_rvalid_i while IDLE or DONE is ignored.
- mem_stall_o is 1 in ACCESS and WAIT_LAST and in the IDLE cycle that starts an access; 0 otherwise.
- Minimum latency with gnt always 1:
  - Store W: stall 4 cycles, DONE in cycle 5.
  - Load W: stall 5 cycles, DONE in cycle 6.
  - Load B: stall 2 cycles, DONE in cycle 3.

Test Plan:
- Non-memory op: memcnf=0, wdata_i=0x0000_1234, wd_i=5, wreg_i=1 -> same cycle wdata_o=0x1234, wd_o=5, wreg_o=1, stall=0, mem_req_o never asserted.
- LW at 0x100, memory bytes 78,56,34,12, gnt=1 always -> addresses 0x100..0x103 issued on consecutive cycles, mem_we_o=0; DONE wdata_o=0x12345678, wreg_o=1; stall high exactly 5 cycles.
- LB/LBU at 0x20 holding 0x80 -> signed gives 0xFFFFFF80; unsigned gives 0x00000080; LH at 0x40 holding 0x00,0x80 signed -> 0xFFFF8000.
- SH wdata_i=0x0000ABCD at 0x202 with gnt low for 3 cycles before each grant -> bytes CD@0x202 then AB@0x203, mem_we_o=1, request held stable while gnt low; DONE wreg_o=0, stall released only after second grant.
- SW at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 (wrap).
- Reset asserted after the second grant of an LW -> next cycle mem_req_o=0, stall=0, all outputs 0; a following LB completes normally with a clean buffer.
